mdu: RTL
========

// Module: mdu
// PURPOSE
//  Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU.
//  Executes MULT/MULTU/DIV/DIVU into the HI/LO register pair.
//  Handles MTHI/MTLO writes and exposes HI/LO to MFHI/MFLO.
//  Drives `busy` so the hazard unit stalls any HI/LO-touching instruction in D.
// PARAMETERS
//  MULT_LAT  5   cycles busy is high for MULT/MULTU (>=1)
//  DIV_LAT   10  cycles busy is high for DIV/DIVU (>=1)
// PORTS
//  clk    in   1   rising-edge clock
//  reset  in   1   asynchronous, active-high; clears all state
//  start  in   1   1-cycle request; op/A/B are valid in that cycle
//  op     in   4   0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MTHI, 0101 MTLO; others = no-op
//  A      in   32  rs operand (dividend / multiplicand / MTHI,MTLO data)
//  B      in   32  rt operand (divisor / multiplier)
//  flush  in   1   exception/interrupt taken this cycle; suppresses a same-cycle start
//  busy   out  1   operation in flight (registered)
//  hi     out  32  HI register (registered)
//  lo     out  32  LO register (registered)
// BEHAVIOUR
//  Reset (async, any cycle incl. mid-op): busy=0, hi=0, lo=0, cnt=0, state=IDLE.
//  FSM states:
//   IDLE: accept start&!flush.
//    - mult/div op: latch A, B and op; cnt<=LAT-1; busy<=1; go to RUN.
//    - MTHI: hi<=A at that edge.
//    - MTLO: lo<=A at that edge.
//    - busy stays 0 for MTHI/MTLO; state stays IDLE.
//   RUN: cnt decrements each cycle.
//    - When cnt==0, at that edge: {hi,lo}<=result, busy<=0, state<=IDLE.
//  Latency: start edge at cycle N gives busy=1 for cycles N+1..N+LAT.
//   New hi/lo are visible from cycle N+LAT+1.
//  hi/lo hold their old values throughout RUN; no partial results are visible.
//  start while busy=1 is ignored (the hazard unit guarantees it does not happen).
//   No queuing; latched operands are not disturbed.
//  flush=1 with start=1: start ignored, no state change.
//   flush during RUN does not abort; the operation completes (it is already committed).
//  Unknown op with start: no-op, busy stays 0.
//  Arithmetic, on latched operands:
//   MULT:  {hi,lo} = $signed(A)*$signed(B), full 64-bit.
//   MULTU: {hi,lo} = A*B, unsigned 64-bit.
//   DIV:   lo = signed quotient (truncate toward 0); hi = remainder with the dividend's sign.
//   DIVU:  lo = A/B, hi = A%B, unsigned.
//   DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
//  Divide by zero: see CONFIGURATION. It still takes DIV_LAT cycles.
//  Result computation may be combinational on latched operands.
//   Only the final-cycle write is architecturally visible.
// CONFIGURATION
//  MDU_DIV0_GUARD_EN
//   defined:   DIV/DIVU with B==0 leaves hi/lo unchanged; busy still asserts DIV_LAT cycles.
//   undefined: B==0 gives lo=32'hFFFFFFFF and hi=A, for both DIV and DIVU.
// TESTING
//  1. Reset asserted mid-RUN (cycle 3 of DIV) -> busy=0, hi=lo=0 immediately.
//     Next start is accepted normally.
//  2. MULT A=0xFFFFFFFE(-2), B=3 -> busy high exactly 5 cycles;
//     then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  3. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
//  4. DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU 7/2 -> lo=3, hi=1.
//  5. start=1 with flush=1, op=MULT -> busy stays 0, hi/lo unchanged.
//     MTHI A=0x1234 with flush=0 -> hi=0x1234 next cycle, busy=0.
//  6. DIV B=0 with hi=0x11, lo=0x22:
//     guard build -> hi/lo stay 0x11/0x22.
//     non-guard build -> lo=0xFFFFFFFF, hi=A.
//     start during RUN is ignored, and the result matches the first op's operands.

Source files
------------

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair
// Optional feature macro: MDU_DIV0_GUARD_EN (divide by zero leaves HI/LO untouched)
module mdu #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [31:0] cnt;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_we;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Signed divide done on magnitudes so 0x80000000 / -1 wraps instead of overflowing.
    assign abs_a = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign abs_b = b_q[31] ? (~b_q + 32'd1) : b_q;
    assign q_mag = (op_q[0] ? a_q : abs_a) / (op_q[0] ? b_q : abs_b);
    assign r_mag = (op_q[0] ? a_q : abs_a) % (op_q[0] ? b_q : abs_b);
    assign q_s   = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s   = a_q[31] ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res_we = 1'b1;
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op_q)
            2'b00: {res_hi, res_lo} = prod_s;
            2'b01: {res_hi, res_lo} = prod_u;
            default: begin
                if (b_q == 32'd0) begin
`ifdef MDU_DIV0_GUARD_EN
                    res_we = 1'b0;
`else
                    res_hi = a_q;
                    res_lo = 32'hFFFF_FFFF;
`endif
                end else if (op_q[0]) begin
                    res_hi = r_mag;
                    res_lo = q_mag;
                end else begin
                    res_hi = r_s;
                    res_lo = q_s;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 32'd0;
            op_q  <= 2'b00;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        if (op[3:2] == 2'b00) begin
                            op_q  <= op[1:0];
                            a_q   <= A;
                            b_q   <= B;
                            cnt   <= op[1] ? 32'(DIV_LAT - 1) : 32'(MULT_LAT - 1);
                            busy  <= 1'b1;
                            state <= RUN;
                        end else if (op == 4'b0100) begin
                            hi <= A;
                        end else if (op == 4'b0101) begin
                            lo <= A;
                        end
                    end
                end
                RUN: begin
                    // Requests arriving here are dropped; operands stay as latched.
                    if (cnt == 32'd0) begin
                        if (res_we) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
